alu_step_sequencer: RTL

Parametrised hardwired control-step generator for the datapath's register-to-register ALU instructions. It drives fetch (T0–T2) and execute (T3–T5/T6) with the datapath's enable and select strobes. It adds features the fixed-sequence controller lacks:
- memory wait states with timeout;
- one-hot register-select decode;
- a two-phase HI/LO writeback for MUL/DIV;
- a start/done handshake to the top-level controller.

---
 rtl/ctrl_step_pkg.sv | 41 ++++
 rtl/reg_sel_decoder.sv | 22 ++
 rtl/alu_step_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_step_pkg.sv
// Shared types and constants for the ALU step sequencer.
// State encoding, default opcodes and ir field-offset helpers.
package ctrl_step_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [4:0] OP_ADD       = 5'b00011;
  localparam logic [4:0] DEF_OP_MUL   = 5'b01111;
  localparam logic [4:0] DEF_OP_DIV   = 5'b10000;
  localparam logic [4:0] DEF_OP_LIMIT = 5'b10001;

  // Select width; a single register still needs one bit.
  function automatic int rsel_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // MSB positions of the ra/rb/rc fields below the opcode.
  function automatic int ra_msb(int dw, int ow);
    return dw - ow - 1;
  endfunction

  function automatic int rb_msb(int dw, int ow, int rw);
    return dw - ow - 1 - rw;
  endfunction

  function automatic int rc_msb(int dw, int ow, int rw);
    return dw - ow - 1 - 2 * rw;
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Binary register select to one-hot enable vector.
// Selects beyond NUM_REGS-1 decode to all zeros.
module reg_sel_decoder #(
  parameter int NUM_REGS = 16,
  parameter int RSEL_W   = 4
) (
  input  logic                en,
  input  logic [RSEL_W-1:0]   sel,
  output logic [NUM_REGS-1:0] onehot
);

  // One-hot decode gated by enable
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (int'(sel) == i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// Hardwired fetch/execute step generator for reg-reg ALU ops.
// Adds memory wait/timeout, HI/LO writeback and start/done.
module alu_step_sequencer
  import ctrl_step_pkg::*;
#(
  parameter int              DATA_W   = 32,
  parameter int              NUM_REGS = 16,
  parameter int              OP_W     = 5,
  parameter logic [OP_W-1:0] OP_MUL   = OP_W'(DEF_OP_MUL),
  parameter logic [OP_W-1:0] OP_DIV   = OP_W'(DEF_OP_DIV),
  parameter logic [OP_W-1:0] OP_LIMIT = OP_W'(DEF_OP_LIMIT),
  parameter int              MAX_WAIT = 15
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   ir,
  output logic                PCout,
  output logic                IncPC,
  output logic                MARin,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowIn,
  output logic                ZHighIn,
  output logic                Zlowout,
  output logic                ZHighout,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [OP_W-1:0]     alu_op,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int RSEL_W = rsel_w(NUM_REGS);
  localparam int WCNT_W = rsel_w(MAX_WAIT + 1);
  localparam int OP_MSB = DATA_W - 1;
  localparam int RA_MSB = ra_msb(DATA_W, OP_W);
  localparam int RB_MSB = rb_msb(DATA_W, OP_W, RSEL_W);
  localparam int RC_MSB = rc_msb(DATA_W, OP_W, RSEL_W);

  localparam logic [WCNT_W-1:0] WCNT_MAX =
    WCNT_W'(MAX_WAIT);

  state_e              state_q;
  state_e              state_d;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [WCNT_W-1:0]   wcnt_d;
  logic [OP_W-1:0]     op_q;
  logic [RSEL_W-1:0]   ra_q;
  logic [RSEL_W-1:0]   rb_q;
  logic [RSEL_W-1:0]   rc_q;

  logic                md;
  logic                illegal;
  logic                ro_en;
  logic                ri_en;
  logic [RSEL_W-1:0]   ro_sel;

  assign md      = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign illegal = (op_q >= OP_LIMIT);

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wcnt_d  = '0;
      end
      S_T1: begin
        if (wcnt_q != WCNT_MAX) begin
          wcnt_d = wcnt_q + 1'b1;
        end
        if (mem_ready) begin
          state_d = S_T2;
        end else if (wcnt_d == WCNT_MAX) begin
          state_d = S_ERR;
        end
      end
      S_T2:   state_d = S_T3;
      S_T3:   state_d = illegal ? S_ERR : S_T4;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = md ? S_T6 : S_DONE;
      S_T6:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter, and ir field capture on T3 entry
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_q == S_T2) begin
        op_q <= ir[OP_MSB -: OP_W];
        ra_q <= ir[RA_MSB -: RSEL_W];
        rb_q <= ir[RB_MSB -: RSEL_W];
        rc_q <= ir[RC_MSB -: RSEL_W];
      end
    end
  end

  // Moore strobe decode of the registered state
  always_comb begin
    PCout    = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZLowIn   = 1'b0;
    ZHighIn  = 1'b0;
    Zlowout  = 1'b0;
    ZHighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    alu_op   = '0;
    done     = 1'b0;
    err      = 1'b0;
    ro_en    = 1'b0;
    ri_en    = 1'b0;
    ro_sel   = rb_q;
    unique case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (wcnt_q == '0) begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
        end
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Yin    = 1'b1;
        ro_en  = 1'b1;
        ro_sel = rb_q;
      end
      S_T4: begin
        ZLowIn  = 1'b1;
        ZHighIn = md;
        alu_op  = op_q;
        ro_en   = 1'b1;
        ro_sel  = rc_q;
      end
      S_T5: begin
        Zlowout = 1'b1;
        LOin    = md;
        ri_en   = !md;
      end
      S_T6: begin
        ZHighout = 1'b1;
        HIin     = 1'b1;
      end
      S_DONE: done = 1'b1;
      S_ERR:  err  = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  reg_sel_decoder #(
    .NUM_REGS (NUM_REGS),
    .RSEL_W   (RSEL_W)
  ) u_dec_out (
    .en     (ro_en),
    .sel    (ro_sel),
    .onehot (reg_out)
  );

  reg_sel_decoder #(
    .NUM_REGS (NUM_REGS),
    .RSEL_W   (RSEL_W)
  ) u_dec_in (
    .en     (ri_en),
    .sel    (ra_q),
    .onehot (reg_in)
  );

endmodule
